// File: rtl/chroni_vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// chroni_vram_arbiter_if
// Requester-side bus of the Chroni VRAM port-B arbiter.
//   req[2:0]      request per requester, held with a stable address until gnt
//   addr0..addr2  per-requester read address
//   gnt[2:0]      one-hot, one-cycle grant pulse
//   rd_valid[2:0] one-hot, one-cycle return strobe
//   rd_data       returned byte, meaningful while any rd_valid bit is high
// master = requesters side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface chroni_vram_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
) ();
   logic [2:0]        req;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [2:0]        gnt;
   logic [2:0]        rd_valid;
   logic [DATA_W-1:0] rd_data;

   modport master (output req, addr0, addr1, addr2,
                   input  gnt, rd_valid, rd_data);
   modport slave  (input  req, addr0, addr1, addr2,
                   output gnt, rd_valid, rd_data);
endinterface

// File: rtl/chroni_vram_arbiter.sv
// ---------------------------------------------------------------------------
// chroni_vram_arbiter
// Shares the fixed-latency VRAM read port B between the line fetch engine (0),
// the attribute/sprite fetch (1) and CPU readback (2). One read is issued per
// cycle; a tag pipeline as deep as the VRAM latency routes each returned byte
// back to its originator, strictly in grant order.
// Requester 0 has fixed priority, 1 and 2 round-robin, and an aging counter on
// 1/2 overrides requester 0 once a request has waited STARVE_LIMIT cycles.
// Ports:
//   sys_clk, reset_n   clock, synchronous active-low reset
//   bus                requester bus (slave side)
//   vram_addr          registered address to VRAM address_b
//   vram_rd_data       VRAM q_b, valid RD_LATENCY cycles after vram_addr
//   starve_override    grant of this cycle came from the aging override
// ---------------------------------------------------------------------------
module chroni_vram_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 8,
   parameter int RD_LATENCY   = 3,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   chroni_vram_arbiter_if.slave  bus,
   output logic [ADDR_W-1:0]     vram_addr,
   input  logic [DATA_W-1:0]     vram_rd_data,
   output logic                  starve_override
);

   typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_R0 = 2'd1, TAG_R1 = 2'd2, TAG_R2 = 2'd3} tag_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [2:0]               gnt_q, gnt_d;
   logic [2:0]               elig;
   logic                     rr_q, rr_d;      // 0: requester 1 next, 1: requester 2 next
   logic [7:0]               age1_q, age1_d;
   logic [7:0]               age2_q, age2_d;
   logic                     ovr_q, ovr_d;
   logic [ADDR_W-1:0]        vram_addr_q, vram_addr_d;
   tag_t [RD_LATENCY-1:0]    tag_q, tag_d;
   logic [2:0]               rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]        rd_data_q, rd_data_d;
   logic                     ov1, ov2, pick2;

   // ------------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------------
   always_comb begin
      // last cycle's winner is masked while it sees gnt and deasserts/updates
      elig  = bus.req & ~gnt_q;
      ov1   = elig[1] && (age1_q >= LIMIT);
      ov2   = elig[2] && (age2_q >= LIMIT);
      gnt_d = 3'b000;
      ovr_d = 1'b0;
      pick2 = rr_q;
      if (ov1 || ov2) begin
         ovr_d = 1'b1;
         if (ov1 && ov2) begin
            // older wins; equal ages fall back to the RR pointer
            if (age1_q != age2_q) pick2 = (age2_q > age1_q);
         end else begin
            pick2 = ov2;
         end
         gnt_d = pick2 ? 3'b100 : 3'b010;
      end else if (elig[0]) begin
         gnt_d = 3'b001;
      end else if (elig[1] && elig[2]) begin
         gnt_d = rr_q ? 3'b100 : 3'b010;
      end else if (elig[1]) begin
         gnt_d = 3'b010;
      end else if (elig[2]) begin
         gnt_d = 3'b100;
      end

      // pointer moves to the requester that was not just served
      rr_d = rr_q;
      if (gnt_d[1])      rr_d = 1'b1;
      else if (gnt_d[2]) rr_d = 1'b0;

      age1_d = (!bus.req[1] || gnt_d[1]) ? 8'd0 :
               (age1_q == 8'hFF) ? age1_q : age1_q + 8'd1;
      age2_d = (!bus.req[2] || gnt_d[2]) ? 8'd0 :
               (age2_q == 8'hFF) ? age2_q : age2_q + 8'd1;

      vram_addr_d = vram_addr_q;
      unique case (gnt_d)
         3'b001:  vram_addr_d = bus.addr0;
         3'b010:  vram_addr_d = bus.addr1;
         3'b100:  vram_addr_d = bus.addr2;
         default: vram_addr_d = vram_addr_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Tag pipeline and return routing
   // ------------------------------------------------------------------------
   always_comb begin
      tag_d = tag_q;
      unique case (gnt_d)
         3'b001:  tag_d[0] = TAG_R0;
         3'b010:  tag_d[0] = TAG_R1;
         3'b100:  tag_d[0] = TAG_R2;
         default: tag_d[0] = TAG_NONE;
      endcase
      for (int k = 1; k < RD_LATENCY; k++) tag_d[k] = tag_q[k-1];

      rd_valid_d = 3'b000;
      unique case (tag_q[RD_LATENCY-1])
         TAG_R0:  rd_valid_d = 3'b001;
         TAG_R1:  rd_valid_d = 3'b010;
         TAG_R2:  rd_valid_d = 3'b100;
         default: rd_valid_d = 3'b000;
      endcase
      rd_data_d = (|rd_valid_d) ? vram_rd_data : rd_data_q;
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         gnt_q       <= 3'b000;
         rr_q        <= 1'b0;
         age1_q      <= 8'd0;
         age2_q      <= 8'd0;
         ovr_q       <= 1'b0;
         vram_addr_q <= '0;
         for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= TAG_NONE;
         rd_valid_q  <= 3'b000;
         rd_data_q   <= '0;
      end else begin
         gnt_q       <= gnt_d;
         rr_q        <= rr_d;
         age1_q      <= age1_d;
         age2_q      <= age2_d;
         ovr_q       <= ovr_d;
         vram_addr_q <= vram_addr_d;
         tag_q       <= tag_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign vram_addr       = vram_addr_q;
   assign starve_override = ovr_q;

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
module tb_chroni_vram_arbiter;
   localparam int ADDR_W       = 17;
   localparam int DATA_W       = 8;
   localparam int RD_LATENCY   = 3;
   localparam int STARVE_LIMIT = 3;

   logic              sys_clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] vram_addr;
   logic [DATA_W-1:0] vram_rd_data;
   logic              starve_override;

   chroni_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   chroni_vram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .RD_LATENCY(RD_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .sys_clk(sys_clk),
      .reset_n(reset_n),
      .bus(bus),
      .vram_addr(vram_addr),
      .vram_rd_data(vram_rd_data),
      .starve_override(starve_override)
   );

   always #5 sys_clk = ~sys_clk;

   // VRAM content is a fixed hash of the address
   function automatic logic [7:0] vmem(input logic [ADDR_W-1:0] a);
      logic [31:0] t;
      t = 32'(a) * 32'd2654435761;
      return t[31:24] ^ a[7:0];
   endfunction

   // VRAM port B: data for the address presented in cycle N is on q in N+RD_LATENCY-1
   logic [ADDR_W-1:0] apipe [1:RD_LATENCY-1];
   always @(posedge sys_clk) begin
      apipe[1] <= vram_addr;
      for (int k = 2; k < RD_LATENCY; k++) apipe[k] <= apipe[k-1];
   end
   assign vram_rd_data = vmem(apipe[RD_LATENCY-1]);

   // reference model state
   typedef struct { int tag; logic [7:0] data; int due; } ret_t;
   ret_t              rq[$];
   int                wait_c [3];
   int                last_g;
   int                rr;
   logic [ADDR_W-1:0] m_vaddr;
   int                cyc;
   int                n_vec = 0;
   int                n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] addr_of(input int i);
      case (i)
         0:       return bus.addr0;
         1:       return bus.addr1;
         default: return bus.addr2;
      endcase
   endfunction

   task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
      case (i)
         0:       bus.addr0 = a;
         1:       bus.addr1 = a;
         default: bus.addr2 = a;
      endcase
   endtask

   function automatic int gidx(input logic [2:0] g);
      case (g)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   // one clock: predict from the spec's rules, advance, compare everything
   task automatic cycle();
      int   g;
      bit   ov, o1, o2;
      bit   e [3];
      logic [31:0] exp_rv;
      logic [7:0]  exp_d;
      for (int i = 0; i < 3; i++) e[i] = bus.req[i] && (last_g != i);
      g  = -1;
      ov = 1'b0;
      o1 = e[1] && (wait_c[1] >= STARVE_LIMIT);
      o2 = e[2] && (wait_c[2] >= STARVE_LIMIT);
      if (o1 || o2) begin
         ov = 1'b1;
         if (o1 && o2) g = (wait_c[1] > wait_c[2]) ? 1 : (wait_c[2] > wait_c[1]) ? 2 : rr;
         else          g = o1 ? 1 : 2;
      end else if (e[0])        g = 0;
      else if (e[1] && e[2])    g = rr;
      else if (e[1])            g = 1;
      else if (e[2])            g = 2;
      if (g >= 0) begin
         m_vaddr = addr_of(g);
         rq.push_back('{g, vmem(m_vaddr), cyc + RD_LATENCY});
      end
      for (int i = 0; i < 3; i++)
         wait_c[i] = (!bus.req[i] || g == i) ? 0 : (wait_c[i] < 255 ? wait_c[i] + 1 : 255);
      if (g == 1)      rr = 2;
      else if (g == 2) rr = 1;
      last_g = g;

      @(posedge sys_clk); #1;
      chk("gnt", 32'(bus.gnt), (g < 0) ? 32'd0 : 32'(1 << g));
      chk("vram_addr", 32'(vram_addr), 32'(m_vaddr));
      chk("starve_override", 32'(starve_override), 32'(ov));
      exp_rv = 32'd0;
      exp_d  = 8'd0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         exp_rv = 32'(1 << rq[0].tag);
         exp_d  = rq[0].data;
         void'(rq.pop_front());
      end
      chk("rd_valid", 32'(bus.rd_valid), exp_rv);
      if (exp_rv != 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_d));
      cyc++;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge sys_clk); #1;
      reset_n = 1'b1;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
      chk("rst_vram_addr", 32'(vram_addr), 32'd0);
      chk("rst_starve", 32'(starve_override), 32'd0);
      rq.delete();
      for (int i = 0; i < 3; i++) wait_c[i] = 0;
      last_g  = -1;
      rr      = 1;
      m_vaddr = '0;
      cyc++;
   endtask

   initial begin
      int seq [$];
      int c1, c2, prev, gi;
      bus.req = 3'b000; bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
      cyc = 0;

      // 1: single request, latency and data
      do_reset();
      bus.addr0 = 17'h1E05; bus.req = 3'b001;
      cycle();
      chk("t1_gnt", 32'(bus.gnt), 32'd1);
      chk("t1_addr", 32'(vram_addr), 32'h1E05);
      bus.req = 3'b000;
      cycle(); cycle();
      chk("t1_early", 32'(bus.rd_valid), 32'd0);
      cycle();
      chk("t1_rv", 32'(bus.rd_valid), 32'd1);
      chk("t1_data", 32'(bus.rd_data), 32'(vmem(17'h1E05)));
      repeat (2) cycle();

      // 2/3: all three held -> 0,1,0,2 with aging taking over 1/2 slots
      do_reset();
      bus.req = 3'b111;
      for (int i = 0; i < 3; i++) set_addr(i, ADDR_W'($urandom));
      for (int k = 0; k < 16; k++) begin
         cycle();
         gi = gidx(bus.gnt);
         seq.push_back(gi);
         if (k >= 3) chk("t3_override", 32'(starve_override), 32'(gi != 0));
         if (gi >= 0) set_addr(gi, ADDR_W'($urandom));
      end
      for (int k = 0; k < 16; k++) begin
         int pat;
         pat = (k % 2 == 0) ? 0 : ((k % 4 == 1) ? 1 : 2);
         chk("t2_seq", 32'(seq[k]), 32'(pat));
      end
      bus.req = 3'b000;
      repeat (5) cycle();
      chk("t2_drain", 32'(rq.size()), 32'd0);

      // 4: round robin between 1 and 2
      do_reset();
      bus.req = 3'b110;
      c1 = 0; c2 = 0; prev = -1;
      for (int k = 0; k < 100; k++) begin
         cycle();
         gi = gidx(bus.gnt);
         if (gi == 1) c1++;
         if (gi == 2) c2++;
         if (k > 0) chk("t4_alt", 32'(gi != prev), 32'd1);
         prev = gi;
         if (gi >= 0) set_addr(gi, ADDR_W'($urandom));
      end
      chk("t4_fair", 32'((c1 > c2 ? c1 - c2 : c2 - c1) <= 1), 32'd1);
      bus.req = 3'b000;
      repeat (5) cycle();

      // 5: reset right after a grant drops the in-flight read
      do_reset();
      bus.addr0 = 17'h0ABCD; bus.req = 3'b001;
      cycle();
      bus.req = 3'b000;
      do_reset();
      repeat (6) cycle();
      bus.addr0 = 17'h1F00F; bus.req = 3'b001;
      cycle();
      bus.req = 3'b000;
      repeat (4) cycle();

      // 6: req2 abandoned while req0 wins
      do_reset();
      bus.addr0 = 17'h00111; bus.addr2 = 17'h00222; bus.req = 3'b101;
      cycle();
      bus.req = 3'b000;
      cycle();
      chk("t6_age2", 32'(dut.age2_q), 32'd0);
      repeat (5) cycle();

      // randomized traffic with occasional resets
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 3; i++) begin
            if (bus.gnt[i]) begin
               bus.req[i] = ($urandom_range(0, 3) != 0);
               set_addr(i, ADDR_W'($urandom));
            end else if (bus.req[i]) begin
               if ($urandom_range(0, 31) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               bus.req[i] = 1'b1;
               set_addr(i, ADDR_W'($urandom));
            end
         end
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle();
      end
      bus.req = 3'b000;
      repeat (6) cycle();
      chk("final_drain", 32'(rq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
